// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   statetype  - FSM state encoding (4-bit)
//   OP_*       - instruction opcode field values
//   F_*        - R-type funct field values
//   ALUOP_*    - aluop encoding handed from the FSM to the ALU decoder
//   ALU_*      - ALU control codes driven to the datapath
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// -----------------------------------------------------------------------------
// aludec
// Combinational ALU decoder.
//   funct      in  6  R-type function field
//   aluop      in  2  operation class from the control FSM
//   alucontrol out 3  ALU operation select
// aluop 00 adds, 01 subtracts, 10 decodes funct; anything unknown adds.
// -----------------------------------------------------------------------------
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore control FSM for the multicycle MIPS-subset datapath. One state per
// cycle; FETCH, MEMRD and MEMWR stall until memready.
//   clk, reset (sync, active-high)
//   op, funct          instruction register fields
//   zero               ALU zero flag (combinational)
//   memready           memory access completes this cycle
//   pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol   datapath controls
//   illegal_op         pulse in DECODE for an unknown opcode
// Optional feature: define MC_BNE_EN to decode bne (000101) through BRANCH.
// -----------------------------------------------------------------------------
module multicycle_controller
  import mc_pkg::*;
#(
  parameter statetype RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  statetype   r_state;
  logic [1:0] w_aluop;
  logic       w_known_op;
`ifdef MC_BNE_EN
  logic       r_isbne;
`endif

  always_comb begin
    w_known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                 (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_BNE_EN
    w_known_op = w_known_op || (op == OP_BNE);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
`ifdef MC_BNE_EN
      r_isbne <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:    if (memready) r_state <= S_DECODE;
        S_DECODE: begin
`ifdef MC_BNE_EN
          r_isbne <= (op == OP_BNE);
`endif
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       r_state <= S_BRANCH;
`endif
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    if (memready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWR:    if (memready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned (no latches).
  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        pcen    = memready;
        irwrite = memready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~w_known_op;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_SUB;
        pcsrc   = 2'b01;
`ifdef MC_BNE_EN
        pcen    = r_isbne ? ~zero : zero;
`else
        pcen    = zero;
`endif
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every architectural write even mid-instruction.
    if (reset) begin
      pcen       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  aludec u_aludec (
    .funct      (funct),
    .aluop      (w_aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Scoreboard bench: the driver walks each instruction through the phases the
// ISA defines, pushing the expected control word for every cycle; a monitor
// compares the DUT outputs at each falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
  } ctl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4,
                 K_ADDI = 5, K_J = 6, K_ILL = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  ctl_t       act;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .pcen       (act.pcen),
    .iord       (act.iord),
    .memwrite   (act.memwrite),
    .irwrite    (act.irwrite),
    .regdst     (act.regdst),
    .memtoreg   (act.memtoreg),
    .regwrite   (act.regwrite),
    .alusrca    (act.alusrca),
    .alusrcb    (act.alusrcb),
    .pcsrc      (act.pcsrc),
    .alucontrol (act.alucontrol),
    .illegal_op (act.illegal_op)
  );

  // Monitor: one expected control word per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s @%0t: got %h want %h", t, $time, act, e);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic ctl_t idle();
    ctl_t c;
    c            = '0;
    c.alucontrol = 3'b010;
    return c;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] o);
    logic l;
    l = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
        (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
`ifdef MC_BNE_EN
    l = l || (o == 6'b000101);
`endif
    return l;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic mr, input logic z,
                      input ctl_t e, input string t);
    reset    = rst;
    memready = mr;
    zero     = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // A stalled phase: 'stalls' cycles with memready low, then one with it high.
  task automatic mem_phase(input int stalls, input ctl_t stall_e,
                           input ctl_t done_e, input string t);
    for (int s = 0; s < stalls; s++) step(1'b0, 1'b0, rbit(), stall_e, t);
    step(1'b0, 1'b1, rbit(), done_e, t);
  endtask

  task automatic fetch_decode(input int fs);
    ctl_t s, d;
    s         = idle();
    s.alusrcb = 2'b01;
    d         = s;
    d.pcen    = 1'b1;
    d.irwrite = 1'b1;
    mem_phase(fs, s, d, "fetch");
    d            = idle();
    d.alusrcb    = 2'b11;
    d.illegal_op = ~legal(op);
    step(1'b0, rbit(), rbit(), d, "decode");
  endtask

  task automatic run(input int kind, input int fs, input int ms, input logic z);
    ctl_t c, w;
    case (kind)
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_R:    op = 6'b000000;
      K_BEQ:  op = 6'b000100;
      K_BNE:  op = 6'b000101;
      K_ADDI: op = 6'b001000;
      K_J:    op = 6'b000010;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (legal(op) || op == 6'b000101) op = 6'($urandom_range(0, 63));
      end
    endcase
    fetch_decode(fs);
    if (!legal(op)) return;
    c = idle();
    case (kind)
      K_LW, K_SW: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        step(1'b0, rbit(), rbit(), c, "memadr");
        c      = idle();
        c.iord = 1'b1;
        if (kind == K_LW) begin
          mem_phase(ms, c, c, "memrd");
          c          = idle();
          c.memtoreg = 1'b1;
          c.regwrite = 1'b1;
          step(1'b0, rbit(), rbit(), c, "memwb");
        end else begin
          c.memwrite = 1'b1;
          mem_phase(ms, c, c, "memwr");
        end
      end
      K_R: begin
        c.alusrca    = 1'b1;
        c.alucontrol = rtype_alu(funct);
        step(1'b0, rbit(), rbit(), c, "execute");
        c          = idle();
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        step(1'b0, rbit(), rbit(), c, "aluwb");
      end
      K_BEQ, K_BNE: begin
        c.alusrca    = 1'b1;
        c.alucontrol = 3'b110;
        c.pcsrc      = 2'b01;
        c.pcen       = (kind == K_BNE) ? ~z : z;
        step(1'b0, rbit(), z, c, "branch");
      end
      K_ADDI: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        step(1'b0, rbit(), rbit(), c, "addiexec");
        w          = idle();
        w.regwrite = 1'b1;
        step(1'b0, rbit(), rbit(), w, "addiwb");
      end
      K_J: begin
        c.pcsrc = 2'b10;
        c.pcen  = 1'b1;
        step(1'b0, rbit(), rbit(), c, "jump");
      end
      default: ;
    endcase
  endtask

  initial begin
    ctl_t c;
    reset    = 1'b1;
    memready = 1'b1;
    zero     = 1'b0;
    op       = 6'b000000;
    funct    = 6'b100000;
    @(posedge clk);
    #1;
    // Reset held in FETCH with memready high: enables must stay low.
    c         = idle();
    c.alusrcb = 2'b01;
    step(1'b1, 1'b1, 1'b0, c, "reset");
    step(1'b1, 1'b1, 1'b0, c, "reset");

    run(K_LW, 0, 0, 1'b0);
    run(K_SW, 0, 3, 1'b0);
    funct = 6'b101010;
    run(K_R, 0, 0, 1'b0);
    run(K_BEQ, 0, 0, 1'b1);
    run(K_BEQ, 0, 0, 1'b0);
    run(K_BNE, 0, 0, 1'b1);
    run(K_BNE, 0, 0, 1'b0);
    run(K_ADDI, 1, 0, 1'b0);
    run(K_J, 2, 0, 1'b0);
    op = 6'b111111;
    fetch_decode(0);

    // Reset while stalled in MEMRD.
    op = 6'b100011;
    fetch_decode(0);
    c         = idle();
    c.alusrca = 1'b1;
    c.alusrcb = 2'b10;
    step(1'b0, 1'b1, 1'b0, c, "memadr");
    c      = idle();
    c.iord = 1'b1;
    step(1'b0, 1'b0, 1'b0, c, "memrd_stall");
    step(1'b1, 1'b0, 1'b0, c, "reset_in_memrd");
    run(K_J, 0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: funct = 6'b100000;
        1: funct = 6'b100010;
        2: funct = 6'b100100;
        3: funct = 6'b100101;
        4: funct = 6'b101010;
        default: funct = 6'($urandom_range(0, 63));
      endcase
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)), rbit());
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control unit for the MIPS-subset processor: one shared memory and one ALU are time-multiplexed across fetch, decode, execute, memory and writeback states.
- Sits beside the multicycle datapath. Takes the instruction-register op/funct fields, the ALU zero flag and a memory ready handshake.
- Drives all datapath muxes and write enables, one state per cycle, stalling on memory.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instruction opcode field, valid from DECODE onward.
- funct  in  6  R-type function field.
- zero  in  1  ALU zero flag, combinational from the datapath.
- memready  in  1  memory access completes this cycle.
- pcen  out  1  PC register write enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 0=rt, 1=rd.
- memtoreg  out  1  register write data select: 0=ALUOut, 1=Data.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0=PC, 1=A.
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
- alucontrol  out  3  ALU operation.
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.

Behaviour:
- Moore FSM with a 4-bit state register. Outputs decode from the state, except the memready and zero gating described below.
- Reset: state <= FETCH. While reset is high, pcen, irwrite, memwrite, regwrite and illegal_op are forced to 0.
- FETCH:
  - Drives iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcen are asserted only in a cycle with memready=1, and the state then moves to DECODE.
  - If memready=0, the state is held and both enables stay 0.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target computed). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle until memready=1, then go to FETCH. memwrite is 0 outside MEMWR.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. Next state FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcen=1. Next state FETCH.
- ALU decode, combinational from aluop and funct:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Unknown funct -> 010.
- Outputs not listed for a state are 0.
- Unreachable state encodings -> FETCH on the next cycle.
- Reset asserted mid-instruction, including while stalled on memready: the state returns to FETCH on the next edge and no write enable fires in that cycle.
- Per-instruction cycle counts with memready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each stall cycle on memready adds 1.

Optional Feature:
- Macro MC_BNE_EN.
- Defined: opcode 000101 (bne) is decoded in DECODE and goes to the BRANCH state, which asserts pcen=~zero for bne and pcen=zero for beq. The opcode is captured into a 1-bit isbne flop in DECODE.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH) and the isbne flop is absent.

Decomposition:
- Package mc_pkg holds:
  - the statetype enum (S_FETCH..S_JUMP)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants
  - ALU control constants
- Sub-module: the existing ALU decoder, aludec(funct, aluop, alucontrol), instantiated unchanged. The FSM stays in this module.

Test Plan:
- reset=1 for 2 cycles with memready=1, then lw (op=100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 only in cycle 5, and pcen=1 only in cycle 1.
- sw with memready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state FETCH. regwrite stays 0 throughout.
- R-type with funct=101010 -> alucontrol=111 in EXECUTE, regdst=1 and regwrite=1 in ALUWB, 4 cycles total.
- beq with zero=1, then beq with zero=0 -> pcen=1 with pcsrc=01 in BRANCH for the first, pcen=0 for the second. With MC_BNE_EN defined, bne gives the inverse result.
- op=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH, with no regwrite or memwrite. Same result for op=000101 when MC_BNE_EN is undefined.
- reset asserted while stalled in MEMRD with memready=0 -> next state FETCH, and regwrite, memwrite, pcen and irwrite are all 0 in the reset cycle.
